// File: rtl/axi_ram_pkg.sv
// Shared types and helpers for the AXI4 RAM slave.
package axi_ram_pkg;

   typedef enum logic [1:0] {
      FIXED = 2'd0,
      INCR  = 2'd1,
      WRAP  = 2'd2
   } burst_t;

   typedef enum logic [1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } resp_t;

   typedef enum logic [1:0] {
      IDLE,
      WR_DATA,
      WR_RESP,
      RD_DATA
   } state_t;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } grant_t;

   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) ||
             (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next beat address for FIXED/INCR/WRAP bursts.
// Illegal WRAP lengths fall back to INCR; caller flags the error.
module axi_burst_addr
   import axi_ram_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [2:0]        size_i,
   input  logic [7:0]        len_i,
   input  logic [1:0]        burst_i,
   output logic [ADDR_W-1:0] next_o,
   output logic              wrap_ok_o
);

   logic [ADDR_W-1:0] bytes;
   logic [ADDR_W-1:0] sum;
   logic [ADDR_W-1:0] bnd_m1;

   always_comb begin
      bytes     = ADDR_W'(1) << size_i;
      sum       = addr_i + bytes;
      bnd_m1    = ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i)
                  - ADDR_W'(1);
      wrap_ok_o = wrap_len_ok(len_i);
      next_o    = addr_i;
      if (burst_i == WRAP && wrap_ok_o)
         next_o = (addr_i & ~bnd_m1) | (sum & bnd_m1);
      else if (burst_i != FIXED)
         next_o = sum & ~(bytes - ADDR_W'(1));
   end

endmodule

// File: rtl/axi_ram_slave.sv
// AXI4 slave over one byte-enable single-port RAM, shared by reads and writes.
// Define AXI_RAM_STALL_EN for LFSR-driven backpressure stress.
module axi_ram_slave
   import axi_ram_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 64,
   parameter int                ID_W      = 4,
   parameter int                MEM_BYTES = 8192,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s_axi_awvalid,
   output logic                s_axi_awready,
   input  logic [ID_W-1:0]     s_axi_awid,
   input  logic [ADDR_W-1:0]   s_axi_awaddr,
   input  logic [7:0]          s_axi_awlen,
   input  logic [2:0]          s_axi_awsize,
   input  logic [1:0]          s_axi_awburst,
   input  logic                s_axi_wvalid,
   output logic                s_axi_wready,
   input  logic [DATA_W-1:0]   s_axi_wdata,
   input  logic [DATA_W/8-1:0] s_axi_wstrb,
   input  logic                s_axi_wlast,
   output logic                s_axi_bvalid,
   input  logic                s_axi_bready,
   output logic [ID_W-1:0]     s_axi_bid,
   output logic [1:0]          s_axi_bresp,
   input  logic                s_axi_arvalid,
   output logic                s_axi_arready,
   input  logic [ID_W-1:0]     s_axi_arid,
   input  logic [ADDR_W-1:0]   s_axi_araddr,
   input  logic [7:0]          s_axi_arlen,
   input  logic [2:0]          s_axi_arsize,
   input  logic [1:0]          s_axi_arburst,
   output logic                s_axi_rvalid,
   input  logic                s_axi_rready,
   output logic [ID_W-1:0]     s_axi_rid,
   output logic [DATA_W-1:0]   s_axi_rdata,
   output logic [1:0]          s_axi_rresp,
   output logic                s_axi_rlast
);

   localparam int STRB_W = DATA_W / 8;
   localparam int LANE_B = $clog2(STRB_W);
   localparam int MEM_AW = $clog2(MEM_BYTES);
   localparam int WORDS  = MEM_BYTES / STRB_W;
   localparam int IDX_W  = MEM_AW - LANE_B;

   state_t              state_q;
   grant_t              grant_q;
   logic [ID_W-1:0]     id_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [7:0]          len_q;
   logic [2:0]          size_q;
   logic [1:0]          burst_q;
   logic [7:0]          cnt_q;
   logic                err_q;
   logic                dec_q;
   logic                issued_q;
   logic                wready_q;
   logic                bvalid_q;
   resp_t               bresp_q;
   logic                rvalid_q;
   logic                rlast_q;
   resp_t               rresp_q;
   logic [DATA_W-1:0]   rdata_q;

   logic                stall_rw;
   logic                stall_a;
   logic                grant_w;
   logic                aw_hs;
   logic                ar_hs;
   logic                w_hs;
   logic                rd_issue;
   logic                last_beat;
   logic                in_range;
   logic                wr_err;
   logic                wr_dec;
   logic                wrap_ok;
   logic [ADDR_W-1:0]   off;
   logic [ADDR_W-1:0]   addr_d;
   logic [IDX_W-1:0]    idx;
   logic [ADDR_W-1:0]   b_addr;
   logic [2:0]          b_size;
   logic [7:0]          b_len;
   logic [1:0]          b_burst;
   logic                idle;

`ifdef AXI_RAM_STALL_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge clk) begin
      if (rst)
         lfsr_q <= 16'hACE1;
      else
         lfsr_q <= {lfsr_q[14:0],
                    lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   assign stall_rw = (lfsr_q[1:0] == 2'b00);
   assign stall_a  = lfsr_q[0];
`else
   assign stall_rw = 1'b0;
   assign stall_a  = 1'b0;
`endif

   assign idle    = (state_q == IDLE);
   assign grant_w = s_axi_awvalid &&
                    (!s_axi_arvalid || grant_q == READ);

   assign s_axi_awready = !rst && idle && grant_w && !stall_a;
   assign s_axi_arready = !rst && idle && s_axi_arvalid &&
                          !grant_w && !stall_a;
   assign s_axi_wready  = !rst && wready_q && !stall_rw;

   assign aw_hs = s_axi_awvalid && s_axi_awready;
   assign ar_hs = s_axi_arvalid && s_axi_arready;
   assign w_hs  = s_axi_wvalid && s_axi_wready;

   // In IDLE the address unit looks at the incoming request so the
   // wrap-length legality is known at accept time.
   assign b_addr  = idle ? (aw_hs ? s_axi_awaddr : s_axi_araddr) : addr_q;
   assign b_size  = idle ? (aw_hs ? s_axi_awsize : s_axi_arsize) : size_q;
   assign b_len   = idle ? (aw_hs ? s_axi_awlen : s_axi_arlen) : len_q;
   assign b_burst = idle ? (aw_hs ? s_axi_awburst : s_axi_arburst)
                         : burst_q;

   axi_burst_addr #(
      .ADDR_W (ADDR_W)
   ) u_addr (
      .addr_i    (b_addr),
      .size_i    (b_size),
      .len_i     (b_len),
      .burst_i   (b_burst),
      .next_o    (addr_d),
      .wrap_ok_o (wrap_ok)
   );

   assign off       = addr_q - BASE_ADDR;
   assign in_range  = off < ADDR_W'(MEM_BYTES);
   assign idx       = off[MEM_AW-1:LANE_B];
   assign last_beat = (cnt_q == len_q);
   assign wr_err    = err_q || (s_axi_wlast != last_beat);
   assign wr_dec    = dec_q || !in_range;
   assign rd_issue  = (state_q == RD_DATA) && !issued_q &&
                      (!rvalid_q || s_axi_rready) && !stall_rw;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         grant_q  <= READ;
         id_q     <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         size_q   <= '0;
         burst_q  <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         dec_q    <= 1'b0;
         issued_q <= 1'b0;
         wready_q <= 1'b0;
         bvalid_q <= 1'b0;
         bresp_q  <= OKAY;
         rvalid_q <= 1'b0;
         rlast_q  <= 1'b0;
         rresp_q  <= OKAY;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (aw_hs || ar_hs) begin
                  id_q     <= aw_hs ? s_axi_awid : s_axi_arid;
                  addr_q   <= b_addr;
                  len_q    <= b_len;
                  size_q   <= b_size;
                  burst_q  <= b_burst;
                  cnt_q    <= '0;
                  dec_q    <= 1'b0;
                  issued_q <= 1'b0;
                  err_q    <= (b_size > 3'(LANE_B)) ||
                              (b_burst == WRAP && !wrap_ok) ||
                              (b_burst == 2'b11);
                  grant_q  <= aw_hs ? WRITE : READ;
                  wready_q <= aw_hs;
                  state_q  <= aw_hs ? WR_DATA : RD_DATA;
               end
            end
            WR_DATA: begin
               if (w_hs) begin
                  addr_q <= addr_d;
                  cnt_q  <= cnt_q + 8'd1;
                  err_q  <= wr_err;
                  dec_q  <= wr_dec;
                  if (last_beat) begin
                     wready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                     bresp_q  <= wr_dec ? DECERR :
                                 (wr_err ? SLVERR : OKAY);
                     state_q  <= WR_RESP;
                  end
               end
            end
            WR_RESP: begin
               if (s_axi_bready) begin
                  bvalid_q <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            RD_DATA: begin
               if (rd_issue) begin
                  rvalid_q <= 1'b1;
                  rlast_q  <= last_beat;
                  rresp_q  <= !in_range ? DECERR :
                              (err_q ? SLVERR : OKAY);
                  addr_q   <= addr_d;
                  cnt_q    <= cnt_q + 8'd1;
                  issued_q <= last_beat;
               end else if (rvalid_q && s_axi_rready) begin
                  rvalid_q <= 1'b0;
                  rlast_q  <= 1'b0;
                  rresp_q  <= OKAY;
                  if (rlast_q)
                     state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // RAM array carries no reset so contents survive rst.
   logic [DATA_W-1:0] mem [WORDS];

   always_ff @(posedge clk) begin
      for (int b = 0; b < STRB_W; b++) begin
         if (w_hs && in_range && s_axi_wstrb[b])
            mem[idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         rdata_q <= '0;
      else if (rd_issue)
         rdata_q <= in_range ? mem[idx] : '0;
   end

   assign s_axi_bvalid = bvalid_q;
   assign s_axi_bid    = id_q;
   assign s_axi_bresp  = bresp_q;
   assign s_axi_rvalid = rvalid_q;
   assign s_axi_rid    = id_q;
   assign s_axi_rdata  = rdata_q;
   assign s_axi_rresp  = rresp_q;
   assign s_axi_rlast  = rlast_q;

endmodule

// File: doc/axi_ram_slave.md
Name: axi_ram_slave

Overview:
- AXI4 slave RAM that terminates the debug AXI master's bus. It is the direct downstream consumer of the JTAG-driven burst master.
- Gives the debug path a self-contained target for burst bring-up on FPGA without the SoC interconnect.
- Supports FIXED, INCR and WRAP bursts, byte strobes and full backpressure on both channels.
- Shares one synchronous single-port RAM between reads and writes.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 64, AXI data width; must be 32 or 64.
- ID_W, 4, AXI ID width.
- MEM_BYTES, 8192, RAM size in bytes; power of two.
- BASE_ADDR, 32'h0, byte address that maps to RAM word 0.

Ports:
- clk input 1: single clock, all logic posedge.
- rst input 1: synchronous, active-high reset.
- s_axi_awvalid/awready: input/output, 1 each.
- s_axi_awid/awaddr/awlen/awsize/awburst: input, ID_W/ADDR_W/8/3/2.
- s_axi_wvalid/wready: input/output, 1 each.
- s_axi_wdata/wstrb/wlast: input, DATA_W/DATA_W/8/1.
- s_axi_bvalid/bready: output/input, 1 each.
- s_axi_bid/bresp: output, ID_W/2.
- s_axi_arvalid/arready: input/output, 1 each.
- s_axi_arid/araddr/arlen/arsize/arburst: input, ID_W/ADDR_W/8/3/2.
- s_axi_rvalid/rready: output/input, 1 each.
- s_axi_rid/rdata/rresp/rlast: output, ID_W/DATA_W/2/1.
- Unused AXI fields (prot, cache, lock, qos, region, user) are not ports; the wrapper ties them off.

Behaviour:
- Reset:
  - State is IDLE.
  - All valid and ready outputs are 0; bresp, rresp, rdata, rid, bid and rlast are 0.
  - last_grant is READ, so a write wins the first tie.
  - RAM contents are preserved. Reset mid-burst abandons the burst: no B or remaining R beats, valids low on the cycle after rst.
- FSM states: IDLE, WR_DATA, WR_RESP, RD_DATA.
- IDLE arbitration:
  - awready = awvalid && grant_w; arready = arvalid && !grant_w (combinational on valid).
  - grant_w = awvalid && (!arvalid || last_grant==READ).
  - An accepted AW latches id, addr, len, size, burst, zeroes beat_cnt, and goes to WR_DATA.
  - An accepted AR does the same and goes to RD_DATA.
  - last_grant updates on each accept.
- WR_DATA:
  - wready = 1.
  - Each wvalid&&wready beat writes the RAM word at addr[log2(MEM_BYTES)-1:log2(DATA_W/8)], with byte enables = wstrb. No write on a decode error.
  - Address advances per burst type, then beat_cnt increments.
  - wlast asserted when beat_cnt!=len, or deasserted when beat_cnt==len, sets the sticky err flag (SLVERR).
  - After the beat with beat_cnt==len, go to WR_RESP.
- WR_RESP:
  - bvalid = 1, held until bready. bid = latched id.
  - bresp = DECERR(2'b11) if any beat was out of range; else SLVERR(2'b10) if err; else OKAY.
  - Return to IDLE on the cycle after handshake.
- RD_DATA:
  - RAM read latency is 1 cycle, so the first rvalid appears 2 cycles after the AR handshake.
  - One-entry output register. The next RAM read issues only when the register is empty or rvalid&&rready.
  - rdata, rresp and rlast stay stable while rvalid&&!rready.
  - rlast on beat len.
  - Out-of-range beat: rdata=0, rresp=DECERR.
  - Return to IDLE after the last-beat handshake.
- Address arithmetic, per beat:
  - bytes = 1<<size.
  - FIXED: address unchanged.
  - INCR: addr+bytes, then aligned down to size.
  - WRAP: boundary = (len+1)*bytes; next = (addr & ~(boundary-1)) | ((addr+bytes) & (boundary-1)).
  - WRAP with len not in {1,3,7,15}: treated as INCR and err set.
  - size > log2(DATA_W/8): err set, beats still consumed.
- Range: in range when (addr-BASE_ADDR) < MEM_BYTES, unsigned, evaluated per beat. A burst may cross out of range partway.

Optional Feature:
- Macro: AXI_RAM_STALL_EN.
- Defined:
  - A 16-bit LFSR (seed 16'hACE1, reset by rst) gates wready and the issue of the next read beat when lfsr[1:0]==2'b00.
  - awready and arready are held low one extra cycle whenever lfsr[0]==1.
  - Purpose: stress master backpressure handling.
- Undefined: no stalls, timing exactly as above.

Decomposition:
- Package axi_ram_pkg:
  - burst_t enum: FIXED=0, INCR=1, WRAP=2.
  - resp_t: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
  - state_t: IDLE, WR_DATA, WR_RESP, RD_DATA.
  - grant_t: READ, WRITE.
- Sub-module axi_burst_addr: combinational next-address and wrap-legality from addr, size, len, burst; shared by both channels.
- RAM is inferred, byte-enable, single port, inside the top.

Test Plan:
1. INCR write, addr 0x100, len 3, size 3, data 0x11..11–0x44..44; read back same burst → bresp OKAY, four R beats matching in order, rlast only on beat 4.
2. WRAP read, len 3, size 3, addr 0x118 → beats from 0x118, 0x100, 0x108, 0x110.
3. Write 64'hFFFF_FFFF_FFFF_FFFF with wstrb 8'h0F over zeroed 0x40; read → 64'h0000_0000_FFFF_FFFF.
4. Write to BASE_ADDR+MEM_BYTES → bresp 2'b11, RAM unchanged. Read the same address → rdata 0, rresp 2'b11.
5. awvalid and arvalid together after reset → write granted first, then read. rready low 5 cycles mid-burst → rdata and rlast stable, no beat lost.
6. rst pulsed during beat 2 of a len 7 write → valids 0 next cycle, no bvalid. A new AW is accepted and completes OKAY, and pre-reset beats 0–1 remain in RAM.
